// File: rtl/ecc_apb_ctrl.sv
// ecc_apb_ctrl: APB register file and one-shot sequencer for the ECC datapath.
// A CTRL write launches a single encode/decode/full operation, the result is
// captured on dp_done, and a watchdog timer aborts a datapath that never answers.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | no operation in flight, registers writable
// S_LAUNCH | dp_start asserted for this single cycle, timer cleared
// S_WAIT   | waiting for dp_done, timer counting toward TIMEOUT-1
// S_CAPTURE| result already latched, one settling cycle before IDLE
module ecc_apb_ctrl #(
    parameter int DATA_WIDTH      = 32,
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int AMBA_WORD       = 32,
    parameter int TIMEOUT         = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [AMBA_ADDR_WIDTH-1:0] paddr,
    input  logic                       psel,
    input  logic                       penable,
    input  logic                       pwrite,
    input  logic [AMBA_WORD-1:0]       pwdata,
    output logic [AMBA_WORD-1:0]       prdata,
    output logic                       pready,
    output logic                       dp_start,
    output logic [1:0]                 dp_op,
    output logic [1:0]                 dp_width,
    output logic [DATA_WIDTH-1:0]      dp_data,
    output logic [DATA_WIDTH-1:0]      dp_noise,
    input  logic                       dp_done,
    input  logic [DATA_WIDTH-1:0]      dp_result,
    input  logic [1:0]                 dp_num_err
);

    localparam int                 TMR_W    = $clog2(TIMEOUT) + 1;
    localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(TIMEOUT - 1);

    localparam logic [2:0] ADDR_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_DATA   = 3'd1;
    localparam logic [2:0] ADDR_WIDTH  = 3'd2;
    localparam logic [2:0] ADDR_NOISE  = 3'd3;
    localparam logic [2:0] ADDR_STATUS = 3'd4;
    localparam logic [2:0] ADDR_RESULT = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LAUNCH  = 2'd1,
        S_WAIT    = 2'd2,
        S_CAPTURE = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            op_q, op_d;
    logic [1:0]            width_q, width_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] noise_q, noise_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic [1:0]            num_err_q, num_err_d;
    logic                  err_q, err_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic [TMR_W-1:0]      timer_q, timer_d;
    logic [AMBA_WORD-1:0]  prdata_q, prdata_d;

    logic [2:0]            reg_sel;
    logic                  wr_en;
    logic                  rd_setup;
    logic [AMBA_WORD-1:0]  rd_data;
    logic                  unused_paddr;

    assign reg_sel      = paddr[4:2];
    assign wr_en        = psel & penable & pwrite;
    assign rd_setup     = psel & ~penable;
    assign unused_paddr = ^{paddr[AMBA_ADDR_WIDTH-1:5], paddr[1:0]};

    // Read mux; unmapped addresses return zero.
    always_comb begin
        rd_data = '0;
        case (reg_sel)
            ADDR_CTRL:   rd_data = AMBA_WORD'(op_q);
            ADDR_DATA:   rd_data = AMBA_WORD'(data_q);
            ADDR_WIDTH:  rd_data = AMBA_WORD'(width_q);
            ADDR_NOISE:  rd_data = AMBA_WORD'(noise_q);
            ADDR_STATUS: rd_data = AMBA_WORD'({num_err_q, err_q, done_q, busy_q});
            ADDR_RESULT: rd_data = AMBA_WORD'(result_q);
            default:     rd_data = '0;
        endcase
    end

    // Sequencer next state plus APB write decode; a write in the same cycle
    // as a sequencer update is applied last so its err flag is never lost.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        width_d   = width_q;
        data_d    = data_q;
        noise_d   = noise_q;
        result_d  = result_q;
        num_err_d = num_err_q;
        err_d     = err_q;
        done_d    = done_q;
        busy_d    = busy_q;
        timer_d   = timer_q;
        prdata_d  = rd_setup ? rd_data : prdata_q;

        case (state_q)
            S_LAUNCH: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // dp_result is only valid alongside dp_done, so it is latched
                // here; dp_done wins over a coincident final timeout cycle.
                if (dp_done) begin
                    result_d  = dp_result;
                    num_err_d = dp_num_err;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = S_CAPTURE;
                end else if (timer_q == TMR_LAST) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_CAPTURE: state_d = S_IDLE;
            default:   state_d = state_q;
        endcase

        if (wr_en) begin
            case (reg_sel)
                ADDR_CTRL: begin
                    if (busy_q || pwdata[1:0] == 2'd3 || width_q == 2'd3) begin
                        err_d = 1'b1;
                    end else begin
                        op_d    = pwdata[1:0];
                        busy_d  = 1'b1;
                        done_d  = 1'b0;
                        err_d   = 1'b0;
                        timer_d = '0;
                        state_d = S_LAUNCH;
                    end
                end
                ADDR_DATA: begin
                    if (busy_q) err_d  = 1'b1;
                    else        data_d = pwdata[DATA_WIDTH-1:0];
                end
                ADDR_WIDTH: begin
                    if (busy_q) err_d   = 1'b1;
                    else        width_d = pwdata[1:0];
                end
                ADDR_NOISE: begin
                    if (busy_q) err_d   = 1'b1;
                    else        noise_d = pwdata[DATA_WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

    // State and register file flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            width_q   <= '0;
            data_q    <= '0;
            noise_q   <= '0;
            result_q  <= '0;
            num_err_q <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            timer_q   <= '0;
            prdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            width_q   <= width_d;
            data_q    <= data_d;
            noise_q   <= noise_d;
            result_q  <= result_d;
            num_err_q <= num_err_d;
            err_q     <= err_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            timer_q   <= timer_d;
            prdata_q  <= prdata_d;
        end
    end

    assign prdata   = prdata_q;
    assign pready   = 1'b1;
    assign dp_start = (state_q == S_LAUNCH);
    assign dp_op    = op_q;
    assign dp_width = width_q;
    assign dp_data  = data_q;
    assign dp_noise = noise_q;

endmodule

// File: tb/tb_ecc_apb_ctrl.sv
// Scoreboard bench for ecc_apb_ctrl: expected read data and expected launch
// parameters are queued by the stimulus, a monitor pops them on each APB read
// access phase and on each dp_start cycle.
module tb_ecc_apb_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] paddr;
    logic        psel, penable, pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        dp_start;
    logic [1:0]  dp_op, dp_width;
    logic [31:0] dp_data, dp_noise;
    logic        dp_done;
    logic [31:0] dp_result;
    logic [1:0]  dp_num_err;

    logic        dp_done_m, stray_done;
    logic [31:0] dp_result_m;
    logic [1:0]  dp_nerr_m;

    int          n_tests = 0;
    int          n_fail  = 0;

    string       rd_name_q[$];
    logic [31:0] rd_exp_q[$];
    logic [67:0] ln_exp_q[$];

    int          dp_lat  = 0;
    logic [31:0] dp_res  = '0;
    logic [1:0]  dp_nerr = '0;

    string       mon_name;
    logic [31:0] mon_exp;
    logic [67:0] mon_ln;

    always #5 clk = ~clk;

    assign dp_done    = dp_done_m | stray_done;
    assign dp_result  = stray_done ? 32'h0000_DEAD : dp_result_m;
    assign dp_num_err = stray_done ? 2'd2 : dp_nerr_m;

    ecc_apb_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .paddr      (paddr),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .pwdata     (pwdata),
        .prdata     (prdata),
        .pready     (pready),
        .dp_start   (dp_start),
        .dp_op      (dp_op),
        .dp_width   (dp_width),
        .dp_data    (dp_data),
        .dp_noise   (dp_noise),
        .dp_done    (dp_done),
        .dp_result  (dp_result),
        .dp_num_err (dp_num_err)
    );

    // Datapath model: answers dp_lat cycles after seeing dp_start (0 = never).
    initial begin
        dp_done_m   = 1'b0;
        dp_result_m = '0;
        dp_nerr_m   = '0;
        forever begin
            @(negedge clk);
            if (dp_start === 1'b1 && dp_lat > 0) begin
                repeat (dp_lat - 1) @(negedge clk);
                dp_result_m = dp_res;
                dp_nerr_m   = dp_nerr;
                dp_done_m   = 1'b1;
                @(negedge clk);
                dp_done_m   = 1'b0;
            end
        end
    end

    // Monitor: compares each read access phase and each dp_start cycle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst === 1'b1 && psel && penable && !pwrite) begin
                n_tests++;
                if (rd_exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_read addr=%h actual=%h required=none", paddr, prdata);
                end else begin
                    mon_name = rd_name_q.pop_front();
                    mon_exp  = rd_exp_q.pop_front();
                    if (prdata !== mon_exp) begin
                        n_fail++;
                        $display("FAIL %s actual=%h required=%h", mon_name, prdata, mon_exp);
                    end
                end
            end
            if (dp_start === 1'b1) begin
                n_tests++;
                if (ln_exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_dp_start op=%0d width=%0d data=%h noise=%h required=no_launch",
                             dp_op, dp_width, dp_data, dp_noise);
                end else begin
                    mon_ln = ln_exp_q.pop_front();
                    if ({dp_op, dp_width, dp_data, dp_noise} !== mon_ln) begin
                        n_fail++;
                        $display("FAIL launch_params actual=%h required=%h",
                                 {dp_op, dp_width, dp_data, dp_noise}, mon_ln);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    task automatic apb_write(input logic [19:0] a, input logic [31:0] d);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [19:0] a, input string nm, input logic [31:0] e);
        rd_name_q.push_back(nm);
        rd_exp_q.push_back(e);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic expect_launch(input logic [1:0] op, input logic [1:0] w,
                                 input logic [31:0] d, input logic [31:0] n);
        ln_exp_q.push_back({op, w, d, n});
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; stray_done = 1'b0;
        #23;
        n_tests++;
        if ({dp_start, dp_op, dp_width, dp_data, dp_noise, prdata, pready} !== {1'b0, 100'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_outputs start=%b op=%0d width=%0d data=%h noise=%h prdata=%h pready=%b required=all_zero_pready_1",
                     dp_start, dp_op, dp_width, dp_data, dp_noise, prdata, pready);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        apb_read(20'h10, "reset_status", 32'h0);
        apb_read(20'h14, "reset_result", 32'h0);
        apb_read(20'h00, "reset_ctrl",   32'h0);

        // Basic encode
        apb_write(20'h04, 32'hA5);
        apb_write(20'h08, 32'h0);
        dp_lat = 3; dp_res = 32'h1234; dp_nerr = 2'd0;
        expect_launch(2'd0, 2'd0, 32'hA5, 32'h0);
        apb_write(20'h00, 32'h0);
        idle(8);
        apb_read(20'h10, "enc_status", 32'h2);
        apb_read(20'h14, "enc_result", 32'h1234);
        apb_read(20'h04, "enc_data",   32'hA5);

        // Timeout, sampled on the last busy cycle and after
        dp_lat = 0;
        expect_launch(2'd0, 2'd0, 32'hA5, 32'h0);
        apb_write(20'h00, 32'h0);
        apb_read(20'h14, "result_while_busy", 32'h1234);
        idle(62);
        apb_read(20'h10, "status_last_wait_cycle", 32'h1);
        apb_read(20'h10, "status_timeout",         32'h4);
        apb_read(20'h14, "result_after_timeout",   32'h1234);

        // Timeout, first cycle back in IDLE
        expect_launch(2'd0, 2'd0, 32'hA5, 32'h0);
        apb_write(20'h00, 32'h0);
        idle(65);
        apb_read(20'h10, "status_timeout_edge", 32'h4);

        // dp_done on the final timeout cycle: done wins
        dp_lat = 65; dp_res = 32'hBEEF; dp_nerr = 2'd0;
        expect_launch(2'd0, 2'd0, 32'hA5, 32'h0);
        apb_write(20'h00, 32'h0);
        idle(70);
        apb_read(20'h10, "status_done_at_timeout", 32'h2);
        apb_read(20'h14, "result_done_at_timeout", 32'hBEEF);

        // Full op with noise, one corrected error
        apb_write(20'h0C, 32'h1);
        dp_lat = 3; dp_res = 32'h5555; dp_nerr = 2'd1;
        expect_launch(2'd2, 2'd0, 32'hA5, 32'h1);
        apb_write(20'h00, 32'h2);
        idle(8);
        apb_read(20'h10, "full_status", 32'hA);
        apb_read(20'h14, "full_result", 32'h5555);
        apb_read(20'h00, "full_ctrl",   32'h2);

        // DATA_IN write while busy is dropped
        dp_lat = 10; dp_res = 32'h77; dp_nerr = 2'd0;
        expect_launch(2'd0, 2'd0, 32'hA5, 32'h1);
        apb_write(20'h00, 32'h0);
        apb_write(20'h04, 32'hFF);
        idle(15);
        apb_read(20'h10, "busy_write_status", 32'h6);
        apb_read(20'h04, "busy_write_data",   32'hA5);
        apb_read(20'h14, "busy_write_result", 32'h77);

        // Decode with uncorrectable error, then WIDTH=3 blocks launch
        dp_lat = 2; dp_res = 32'h11; dp_nerr = 2'd2;
        expect_launch(2'd1, 2'd0, 32'hA5, 32'h1);
        apb_write(20'h00, 32'h1);
        idle(6);
        apb_read(20'h10, "dec_status", 32'h12);
        apb_write(20'h08, 32'h3);
        apb_read(20'h10, "width3_written_status", 32'h12);
        apb_write(20'h00, 32'h0);
        idle(4);
        apb_read(20'h10, "width3_launch_status", 32'h16);
        apb_read(20'h00, "width3_ctrl",          32'h1);
        apb_read(20'h08, "width3_width",         32'h3);

        // Valid 32b launch, then CTRL op=3 blocked; RO/unmapped access
        apb_write(20'h08, 32'h2);
        dp_lat = 2; dp_res = 32'h22; dp_nerr = 2'd0;
        expect_launch(2'd0, 2'd2, 32'hA5, 32'h1);
        apb_write(20'h00, 32'h0);
        idle(6);
        apb_read(20'h10, "w32_status", 32'h2);
        apb_write(20'h00, 32'h3);
        idle(4);
        apb_read(20'h10, "op3_status", 32'h6);
        apb_read(20'h00, "op3_ctrl",   32'h0);
        apb_write(20'h10, 32'hFFFF);
        apb_read(20'h10, "ro_write_status", 32'h6);
        apb_read(20'h18, "unmapped_read",   32'h0);
        apb_read(20'hFFF14, "alias_result", 32'h22);

        // Reset in WAIT, then a stray dp_done
        dp_lat = 0;
        expect_launch(2'd0, 2'd2, 32'hA5, 32'h1);
        apb_write(20'h00, 32'h0);
        idle(5);
        #2 rst = 1'b0;
        #1;
        n_tests++;
        if ({dp_start, dp_op, dp_width, dp_data, dp_noise, prdata} !== 100'b0) begin
            n_fail++;
            $display("FAIL async_reset_outputs start=%b op=%0d width=%0d data=%h noise=%h prdata=%h required=all_zero",
                     dp_start, dp_op, dp_width, dp_data, dp_noise, prdata);
        end
        @(negedge clk);
        rst = 1'b1;
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        idle(2);
        apb_read(20'h10, "post_reset_status", 32'h0);
        apb_read(20'h14, "post_reset_result", 32'h0);
        apb_read(20'h04, "post_reset_data",   32'h0);
        apb_read(20'h08, "post_reset_width",  32'h0);

        idle(5);
        n_tests++;
        if (rd_exp_q.size() != 0 || ln_exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_expectations reads=%0d launches=%0d required=0",
                     rd_exp_q.size(), ln_exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
